lcm_from_gcd: RTL and testbench
===============================

Name: lcm_from_gcd

Overview:
- Downstream stage of the binary GCD unit. Consumes the operand pair (a, b) and the GCD result g that the GCD unit produces for that pair.
- Computes lcm(a, b) = (a / g) * b with a sequential restoring divider followed by a shift-add multiplier.
- Uses the same start/busy/valid handshake as the GCD unit, so the controller can chain the two blocks: gcd valid_o drives lcm start_i, with a_i/b_i held by the controller.

Parameters:
WIDTH, 32, operand and GCD width; result width is 2*WIDTH.

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  launch request, sampled only in IDLE
a_i  in  WIDTH  operand a
b_i  in  WIDTH  operand b
gcd_i  in  WIDTH  gcd(a, b) from the GCD stage
busy_o  out  1  high in CHECK, DIV, MUL
valid_o  out  1  one-cycle result strobe (DONE state)
error_o  out  1  result invalid (g == 0 or g does not divide a); held with result
lcm_o  out  2*WIDTH  result register, held until the next accepted start

Behaviour:
- Reset (rst_ni low, asynchronous, any state including mid-operation):
  - state = IDLE.
  - busy_o = 0, valid_o = 0, error_o = 0, lcm_o = 0.
  - All internal registers (quotient, remainder, multiplicand, product, counter) = 0.
- States: IDLE, CHECK, DIV, MUL, DONE.
- IDLE: busy_o = 0. If start_i = 1 at edge T:
  - Capture a_i, b_i, gcd_i into registers.
  - Clear lcm_o and error_o.
  - Go to CHECK.
  - Inputs need not be held after edge T.
- CHECK (one cycle):
  - If a == 0 or b == 0: lcm = 0, error = 0, go to DONE.
  - Else if g == 0: lcm = 0, error = 1, go to DONE.
  - Else: clear quotient, remainder, and counter; go to DIV.
- DIV (exactly WIDTH cycles): one restoring step per cycle, MSB first.
  - rem = {rem, a[msb]}; a shifts left one bit.
  - If rem >= g: rem -= g and quotient bit = 1.
  - Remainder register is WIDTH+1 bits so the compare never overflows.
  - On the last step (counter == WIDTH-1), evaluate the final remainder:
    - Final remainder != 0: lcm = 0, error = 1, go to DONE.
    - Otherwise: load multiplier = quotient, multiplicand = b zero-extended to 2*WIDTH, product = 0, counter = 0; go to MUL.
- MUL (exactly WIDTH cycles):
  - Each cycle: if multiplier[0] = 1, product += multiplicand; multiplier >>= 1; multiplicand <<= 1.
  - After WIDTH cycles: lcm_o = product (exact, no truncation since q*b < 2^(2*WIDTH)); go to DONE.
- DONE (one cycle): valid_o = 1, busy_o = 0. Unconditionally go to IDLE.
- start_i handling:
  - start_i in CHECK, DIV, MUL, or DONE is ignored; it is not queued.
  - start_i is accepted again from the first IDLE cycle.
- Latency, counted from start-sampling edge T to the cycle valid_o is high:
  - Zero/g==0 path: 2 cycles.
  - Remainder-error path: WIDTH+2 = 34 cycles.
  - Normal path: 2*WIDTH+2 = 66 cycles.
- lcm_o and error_o are registered; they remain stable from DONE until the next accepted start.

Test Plan:
- a=12, b=18, g=6, start pulse -> busy_o high for 65 cycles, valid_o at cycle 66, lcm_o=36, error_o=0; lcm_o still 36 ten cycles later.
- a=0, b=5, g=5 -> valid_o at cycle 2, lcm_o=0, error_o=0. Repeat with a=7, b=7, g=0 -> cycle 2, lcm_o=0, error_o=1.
- a=0xFFFFFFFF, b=0xFFFFFFFE, g=1 -> cycle 66, lcm_o=0xFFFFFFFD00000002, error_o=0.
- a=10, b=4, g=3 (inconsistent GCD) -> valid_o at cycle 34, lcm_o=0, error_o=1.
- a=21, b=6, g=3, second start pulse at cycle 10 with a=4, b=6, g=2 -> second start ignored, lcm_o=42 at cycle 66. A new start in the following IDLE cycle -> lcm_o=12 after 66 cycles.
- Start a=12, b=18, g=6; drop rst_ni at cycle 40 (mid-MUL) -> busy_o, valid_o, lcm_o, error_o all 0 immediately without a clock edge. After release, start a=9, b=6, g=3 -> lcm_o=18.

Source files
------------

// File: rtl/lcm_from_gcd.sv
// LCM stage chained after the binary GCD unit: lcm(a, b) = (a / g) * b using a
// restoring divider followed by a shift-add multiplier, with a start/busy/valid handshake.
module lcm_from_gcd #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [WIDTH-1:0]   gcd_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic               error_o,
    output logic [2*WIDTH-1:0] lcm_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_DIV   = 3'd2;
    localparam logic [2:0] ST_MUL   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   g_q, g_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] lcm_q, lcm_d;
    logic               err_q, err_d;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_step;
    logic               quo_bit;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] prod_add;
    logic               last_step;

    // One restoring-division step; the extra remainder bit keeps the compare exact.
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
        quo_bit   = (rem_shift >= {1'b0, g_q});
        rem_step  = quo_bit ? (rem_shift - {1'b0, g_q}) : rem_shift;
        quo_next  = {quo_q[WIDTH-2:0], quo_bit};
        prod_add  = quo_q[0] ? (prod_q + mcand_q) : prod_q;
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        lcm_d   = lcm_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    g_d     = gcd_i;
                    lcm_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (a_q == '0 || b_q == '0) begin
                    lcm_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (g_q == '0) begin
                    lcm_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                a_d   = a_q << 1;
                rem_d = rem_step;
                quo_d = quo_next;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    if (rem_step != '0) begin
                        lcm_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        // Quotient register doubles as the multiplier from here on.
                        mcand_d = {{WIDTH{1'b0}}, b_q};
                        prod_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                prod_d  = prod_add;
                quo_d   = quo_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_step) begin
                    lcm_d   = prod_add;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            lcm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            lcm_q   <= lcm_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        busy_o  = (state_q == ST_CHECK) || (state_q == ST_DIV) || (state_q == ST_MUL);
        valid_o = (state_q == ST_DONE);
        error_o = err_q;
        lcm_o   = lcm_q;
    end

endmodule

// File: tb/tb_lcm_from_gcd.sv
// Directed bench for lcm_from_gcd: latency, busy span, result and error flag per vector,
// start-while-busy rejection, result hold and asynchronous reset mid-operation.
module tb_lcm_from_gcd;

    localparam int unsigned WIDTH = 32;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               start_i = 1'b0;
    logic [WIDTH-1:0]   a_i = '0;
    logic [WIDTH-1:0]   b_i = '0;
    logic [WIDTH-1:0]   gcd_i = '0;
    logic               busy_o;
    logic               valid_o;
    logic               error_o;
    logic [2*WIDTH-1:0] lcm_o;

    int checks = 0;
    int failures = 0;

    lcm_from_gcd #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .gcd_i   (gcd_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .error_o (error_o),
        .lcm_o   (lcm_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation from IDLE and wait for valid_o; optionally pulse a second
    // start (4, 6, 2) at cycle inj, which must be ignored.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] g, input int exp_lat, input logic [63:0] exp_lcm,
                       input logic exp_err, input int inj);
        int cyc;
        int busy_cnt;
        tick();
        a_i     = a;
        b_i     = b;
        gcd_i   = g;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        a_i     = 32'hdead_beef;
        b_i     = 32'h1234_5678;
        gcd_i   = 32'h0000_0007;
        cyc      = 1;
        busy_cnt = 0;
        while (!valid_o && cyc < 200) begin
            if (busy_o) busy_cnt++;
            if (cyc == inj) begin
                a_i     = 32'd4;
                b_i     = 32'd6;
                gcd_i   = 32'd2;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            tick();
            cyc++;
        end
        start_i = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        chk({tag, "_lcm"}, lcm_o, exp_lcm);
        chk({tag, "_error"}, 64'(error_o), 64'(exp_err));
    endtask

    initial begin
        #12;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_error", 64'(error_o), 64'd0);
        chk("reset_lcm", lcm_o, 64'd0);
        rst_ni = 1'b1;

        run("lcm_12_18", 32'd12, 32'd18, 32'd6, 66, 64'd36, 1'b0, 0);
        repeat (10) tick();
        chk("hold_lcm", lcm_o, 64'd36);
        chk("hold_error", 64'(error_o), 64'd0);
        chk("hold_valid", 64'(valid_o), 64'd0);

        run("zero_a", 32'd0, 32'd5, 32'd5, 2, 64'd0, 1'b0, 0);
        run("gcd_zero", 32'd7, 32'd7, 32'd0, 2, 64'd0, 1'b1, 0);
        run("max_ops", 32'hffff_ffff, 32'hffff_fffe, 32'd1, 66,
            64'hffff_fffd_0000_0002, 1'b0, 0);
        run("bad_gcd", 32'd10, 32'd4, 32'd3, 34, 64'd0, 1'b1, 0);
        run("ignore_start", 32'd21, 32'd6, 32'd3, 66, 64'd42, 1'b0, 10);
        run("after_ignore", 32'd4, 32'd6, 32'd2, 66, 64'd12, 1'b0, 0);

        // Asynchronous reset in the middle of MUL.
        tick();
        a_i     = 32'd12;
        b_i     = 32'd18;
        gcd_i   = 32'd6;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (39) tick();
        chk("pre_reset_busy", 64'(busy_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy_o), 64'd0);
        chk("async_rst_valid", 64'(valid_o), 64'd0);
        chk("async_rst_error", 64'(error_o), 64'd0);
        chk("async_rst_lcm", lcm_o, 64'd0);
        #10;
        rst_ni = 1'b1;
        run("post_reset", 32'd9, 32'd6, 32'd3, 66, 64'd18, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
